// File: rtl/rr_bus_arbiter_4_pkg.sv
// rr_bus_arbiter_4_pkg
//   Shared definitions for the four-requester round-robin bus arbiter:
//   - the FSM state type;
//   - the requester count NREQ;
//   - the round-robin pick function.
package rr_bus_arbiter_4_pkg;

    localparam int NREQ = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_e;

    // Returns the first requester with req set, searching circularly from
    // last+1. The loop runs from the farthest candidate (last itself) to the
    // nearest (last+1), so the nearest match is the last assignment and wins.
    // When req is all zero the result is last, but callers only use the
    // result when some req bit is set.
    function automatic logic [1:0] rr_pick(input logic [3:0] req,
                                           input logic [1:0] last);
        logic [1:0] idx;
        rr_pick = last;
        for (int i = NREQ; i >= 1; i--) begin
            idx = last + 2'(i);
            if (req[idx]) rr_pick = idx;
        end
    endfunction

endpackage

// File: rtl/rr_bus_arbiter_4_mux.sv
// Mux_4x1
//   Combinational 4:1 word multiplexer.
//   Ports:
//     d0..d3  in  N  data inputs
//     s0, s1  in  1  select (s1 is the high bit): 00->d0, 01->d1, 10->d2, 11->d3
//     y       out N  selected word
module Mux_4x1 #(
    parameter int N = 32
) (
    input  logic [N-1:0] d0,
    input  logic [N-1:0] d1,
    input  logic [N-1:0] d2,
    input  logic [N-1:0] d3,
    input  logic         s0,
    input  logic         s1,
    output logic [N-1:0] y
);
    always_comb begin
        case ({s1, s0})
            2'b00:   y = d0;
            2'b01:   y = d1;
            2'b10:   y = d2;
            default: y = d3;
        endcase
    end
endmodule

// File: rtl/rr_bus_arbiter_4.sv
// rr_bus_arbiter_4
//   Round-robin arbiter that shares one N-bit destination bus between four
//   requesters. A grant is held for a burst of valid/ready beats. There is
//   always one IDLE cycle between grants.
//   Ports:
//     clk        in  1   clock, rising edge
//     rst_n      in  1   synchronous active-low reset
//     req        in  4   per-requester bus request (level)
//     data0..3   in  N   per-requester words
//     out_ready  in  1   consumer accepts current beat
//     gnt        out 4   registered one-hot grant
//     sel        out 2   registered mux select
//     out_valid  out 1   beat present on out_data
//     out_data   out N   selected requester word
//     ack        out 4   per-requester beat-accepted strobe
//   Build option: define RR_ARB_BURST_LIMIT_EN to force a release after
//   MAX_BURST accepted beats. Without it, the owner keeps the bus until its
//   req drops.
module rr_bus_arbiter_4
    import rr_bus_arbiter_4_pkg::*;
#(
    parameter int N         = 32,
    parameter int MAX_BURST = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic [N-1:0]    data0,
    input  logic [N-1:0]    data1,
    input  logic [N-1:0]    data2,
    input  logic [N-1:0]    data3,
    input  logic            out_ready,
    output logic [NREQ-1:0] gnt,
    output logic [1:0]      sel,
    output logic            out_valid,
    output logic [N-1:0]    out_data,
    output logic [NREQ-1:0] ack
);

`ifdef RR_ARB_BURST_LIMIT_EN
    localparam logic LIMIT_EN = 1'b1;
`else
    localparam logic LIMIT_EN = 1'b0;
`endif
    localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

    state_e          state_q, state_d;
    logic [1:0]      owner_q, owner_d;
    logic [1:0]      last_q,  last_d;
    logic [7:0]      beat_cnt_q, beat_cnt_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [1:0]      sel_q, sel_d;

    logic       xfer;
    logic       burst_hit;
    logic [1:0] winner;

    assign out_valid = (state_q == OWN) & req[owner_q];
    assign xfer      = out_valid & out_ready;
    assign ack       = gnt_q & {NREQ{xfer}};
    assign gnt       = gnt_q;
    assign sel       = sel_q;
    assign winner    = rr_pick(req, last_q);

    // The burst release uses the accepted beat itself, so the counter value
    // seen is one behind: hitting MAX_BURST-1 here means the MAX_BURST-th beat.
    assign burst_hit = LIMIT_EN & xfer & (beat_cnt_q == BURST_LAST);

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        beat_cnt_d = beat_cnt_q;
        gnt_d      = gnt_q;
        sel_d      = sel_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d    = OWN;
                    owner_d    = winner;
                    gnt_d      = 4'b0001 << winner;
                    sel_d      = winner;
                    beat_cnt_d = 8'd0;
                end
            end
            default: begin
                if (!req[owner_q] || burst_hit) begin
                    state_d    = IDLE;
                    gnt_d      = '0;
                    last_d     = owner_q;
                    beat_cnt_d = 8'd0;
                end else if (xfer && beat_cnt_q != 8'hFF) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            owner_q    <= 2'd0;
            last_q     <= 2'd3;
            beat_cnt_q <= 8'd0;
            gnt_q      <= '0;
            sel_q      <= 2'd0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            beat_cnt_q <= beat_cnt_d;
            gnt_q      <= gnt_d;
            sel_q      <= sel_d;
        end
    end

    Mux_4x1 #(.N(N)) u_mux (
        .d0 (data0),
        .d1 (data1),
        .d2 (data2),
        .d3 (data3),
        .s0 (sel_q[0]),
        .s1 (sel_q[1]),
        .y  (out_data)
    );

endmodule

// File: tb/tb_rr_bus_arbiter_4.sv
// tb_rr_bus_arbiter_4
//   Directed bench for rr_bus_arbiter_4 (N=32, MAX_BURST=4). The burst
//   rotation checks follow RR_ARB_BURST_LIMIT_EN the same way the design does.
module tb_rr_bus_arbiter_4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] data0, data1, data2, data3;
    logic        out_ready;
    logic [3:0]  gnt;
    logic [1:0]  sel;
    logic        out_valid;
    logic [31:0] out_data;
    logic [3:0]  ack;

    int total = 0;
    int bad   = 0;
    logic [31:0] dvals [4];

    always #5 clk = ~clk;

    rr_bus_arbiter_4 #(.N(32), .MAX_BURST(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .data0     (data0),
        .data1     (data1),
        .data2     (data2),
        .data3     (data3),
        .out_ready (out_ready),
        .gnt       (gnt),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .ack       (ack)
    );

    typedef struct {
        logic [3:0] req;
        logic       rdy;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       vld;
        logic [3:0] ack;
    } vec_t;

    vec_t vecs [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Inputs change 2 time units after the rising edge. Checks happen after a
    // further 1 unit, well away from the next edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = 4'b0000;
        out_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic chk_all(input string tag, input logic [3:0] eg, input logic [1:0] es,
                           input logic ev, input logic [3:0] ea);
        chk({tag, ".gnt"}, 32'(gnt), 32'(eg));
        chk({tag, ".sel"}, 32'(sel), 32'(es));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(ev));
        chk({tag, ".ack"}, 32'(ack), 32'(ea));
        chk({tag, ".out_data"}, out_data, dvals[es]);
    endtask

    initial begin
        dvals[0] = 32'hA000_0000; dvals[1] = 32'hB111_1111;
        dvals[2] = 32'hC222_2222; dvals[3] = 32'hD333_3333;
        data0 = dvals[0]; data1 = dvals[1]; data2 = dvals[2]; data3 = dvals[3];

        // Vectors: reset idle, grant to 1, drop after 2 beats, bubble, grant to 2.
        for (int i = 0; i < 5; i++) vecs.push_back('{4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 4'b0000});
        vecs.push_back('{4'b0110, 1'b1, 4'b0000, 2'd0, 1'b0, 4'b0000});
        vecs.push_back('{4'b0110, 1'b1, 4'b0010, 2'd1, 1'b1, 4'b0010});
        vecs.push_back('{4'b0110, 1'b1, 4'b0010, 2'd1, 1'b1, 4'b0010});
        vecs.push_back('{4'b0100, 1'b1, 4'b0010, 2'd1, 1'b0, 4'b0000});
        vecs.push_back('{4'b0100, 1'b1, 4'b0000, 2'd1, 1'b0, 4'b0000});
        vecs.push_back('{4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, 4'b0100});

        do_reset();
        for (int i = 0; i < vecs.size(); i++) begin
            req = vecs[i].req;
            out_ready = vecs[i].rdy;
            #1;
            chk_all($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].sel, vecs[i].vld, vecs[i].ack);
            tick();
        end

        // Owner 2 has one accepted beat. Stall for three cycles, then accept one beat.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk_all($sformatf("stall%0d", i), 4'b0100, 2'd2, 1'b1, 4'b0000);
            chk($sformatf("stall%0d.beat_cnt", i), 32'(dut.beat_cnt_q), 32'd1);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk_all("unstall", 4'b0100, 2'd2, 1'b1, 4'b0100);
        tick();
        #1;
        chk("unstall.beat_cnt", 32'(dut.beat_cnt_q), 32'd2);
        req = 4'b0000;
        tick();
        tick();

        // All four request constantly.
        do_reset();
        req = 4'b1111;
        out_ready = 1'b1;
        #1;
        chk_all("rr.idle0", 4'b0000, 2'd0, 1'b0, 4'b0000);
        tick();
`ifdef RR_ARB_BURST_LIMIT_EN
        for (int g = 0; g < 5; g++) begin
            for (int b = 0; b < 4; b++) begin
                #1;
                chk_all($sformatf("rr.g%0d.b%0d", g, b), 4'b0001 << (g % 4),
                        2'(g % 4), 1'b1, 4'b0001 << (g % 4));
                tick();
            end
            if (g < 4) begin
                #1;
                chk($sformatf("rr.g%0d.bubble.gnt", g), 32'(gnt), 32'd0);
                chk($sformatf("rr.g%0d.bubble.ack", g), 32'(ack), 32'd0);
                tick();
            end
        end
`else
        for (int c = 0; c < 20; c++) begin
            #1;
            chk_all($sformatf("hold.c%0d", c), 4'b0001, 2'd0, 1'b1, 4'b0001);
            tick();
        end
        repeat (300) tick();
        #1;
        chk("hold.sat.beat_cnt", 32'(dut.beat_cnt_q), 32'd255);
        chk("hold.sat.gnt", 32'(gnt), 32'b0001);
        chk("hold.sat.ack", 32'(ack), 32'b0001);
`endif

        // Reset mid-burst while requester 3 owns the bus.
        do_reset();
        req = 4'b1000;
        out_ready = 1'b1;
        tick();
        #1;
        chk_all("r3.own", 4'b1000, 2'd3, 1'b1, 4'b1000);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        chk("r3.rst.gnt", 32'(gnt), 32'd0);
        chk("r3.rst.out_valid", 32'(out_valid), 32'd0);
        chk("r3.rst.ack", 32'(ack), 32'd0);
        tick();
        #1;
        chk_all("r3.regrant", 4'b1000, 2'd3, 1'b1, 4'b1000);
        req = 4'b0000;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
